capture_pattern: RTL and testbench

//  Reader counterpart of the pattern writer: copies the 8x8 window of the Conway board whose top-left is the cursor into a 64-bit pattern register.
//  The same window is written into the board when a pattern is drawn.

---
 rtl/capture_pattern_pkg.sv | 48 ++++
 rtl/capture_pattern_window_row_read.sv | 38 +++
 rtl/capture_pattern.sv | 156 +++++++++++++++
 tb/tb_capture_pattern.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/capture_pattern_pkg.sv
// rtl/capture_pattern_pkg.sv - shared board geometry, FSM encoding and cell helpers
//
// Purpose:
//   Board and window dimensions, the capture FSM state type and the helpers
//   used to turn (x,y) board coordinates into a bit index of the state bus.
//   The drawing path relies on the same cell_idx mapping, so a captured window
//   can be redrawn at another cursor position without any bit reordering.
// Contents:
//   MAX_X, MAX_Y   board width/height in cells
//   PAT_W, PAT_H   capture window width/height
//   STATE_W        width of the flattened board bus
//   cap_state_t    IDLE -> SCAN -> DONE -> IDLE
//   wrap_add       base+off with a single conditional subtract of the limit
//   cell_idx       y*MAX_X + x

package capture_pattern_pkg;

   localparam int MAX_X   = 64;
   localparam int MAX_Y   = 48;
   localparam int PAT_W   = 8;
   localparam int PAT_H   = 8;
   localparam int STATE_W = MAX_X * MAX_Y;

   localparam logic [7:0] MAX_X8 = 8'(MAX_X);
   localparam logic [7:0] MAX_Y8 = 8'(MAX_Y);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cap_state_t;

   // Operands are always < limit (<= 64) and off <= 7, so the 8-bit sum
   // cannot overflow and one subtract brings it back into range.
   function automatic logic [7:0] wrap_add(input logic [7:0] base,
                                           input logic [7:0] off,
                                           input logic [7:0] lim);
      logic [7:0] sum;
      sum = base + off;
      return (sum >= lim) ? (sum - lim) : sum;
   endfunction

   function automatic logic [11:0] cell_idx(input logic [7:0] x,
                                            input logic [7:0] y);
      return ({4'b0000, y} * 12'(MAX_X)) + {4'b0000, x};
   endfunction

endpackage

// File: rtl/capture_pattern_window_row_read.sv
// rtl/capture_pattern_window_row_read.sv - combinational read of one wrapped window row
//
// Purpose:
//   Picks the PAT_W cells of board row y starting at column col_base, wrapping
//   past the right edge back to column 0, and reports how many are live.
// Ports:
//   state     in   STATE_W  flattened board, cell (x,y) = state[y*MAX_X + x]
//   row_y     in   8        board row to read, already wrapped into 0..MAX_Y-1
//   col_base  in   8        leftmost window column, 0..MAX_X-1
//   bits      out  PAT_W    bit c = cell (col_base+c mod MAX_X, row_y)
//   pop       out  4        number of set bits in bits, 0..PAT_W

module window_row_read
   import capture_pattern_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [7:0]         row_y,
   input  logic [7:0]         col_base,
   output logic [PAT_W-1:0]   bits,
   output logic [3:0]         pop
);

   logic [7:0] col;

   always_comb begin
      bits = '0;
      col  = '0;
      for (int c = 0; c < PAT_W; c++) begin
         col     = wrap_add(col_base, 8'(c), MAX_X8);
         bits[c] = state[cell_idx(col, row_y)];
      end
   end

   always_comb begin
      pop = 4'($countones(bits));
   end

endmodule

// File: rtl/capture_pattern.sv
// rtl/capture_pattern.sv - copy an 8x8 toroidal board window into a pattern register
//
// Purpose:
//   On a capture request while the game is frozen, latches the cursor and
//   scans one window row per clock into a shadow buffer while accumulating
//   the live-cell count. The visible pattern and count are updated together
//   in the single DONE cycle, so a rejected request, an abort or a reset
//   mid-scan never exposes a partial window.
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous active-low reset
//   freeze       in   1        game paused; required to start and to keep scanning
//   capture      in   1        request, level-sampled only in IDLE
//   cursor_x     in   8        window left column
//   cursor_y     in   8        window top row
//   state        in   STATE_W  board, read live one row per SCAN cycle
//   pattern_mat  out  64       bit r*PAT_W+c = cell (cx+c, cy+r), toroidal
//   pop_count    out  7        live cells in pattern_mat
//   busy         out  1        high while scanning
//   done         out  1        one-cycle pulse when pattern_mat/pop_count update
//   err          out  1        one-cycle pulse on rejected request or abort

module capture_pattern
   import capture_pattern_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     freeze,
   input  logic                     capture,
   input  logic [7:0]               cursor_x,
   input  logic [7:0]               cursor_y,
   input  logic [STATE_W-1:0]       state,
   output logic [PAT_W*PAT_H-1:0]   pattern_mat,
   output logic [6:0]               pop_count,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   cap_state_t              fsm_q;
   cap_state_t              fsm_d;

   logic [7:0]              cx_q;
   logic [7:0]              cy_q;
   logic [2:0]              row_q;
   logic [PAT_W*PAT_H-1:0]  shadow_q;
   logic [6:0]              acc_q;

   logic                    accept;
   logic                    reject;
   logic                    abort;
   logic                    scan_step;

   logic [7:0]              row_y;
   logic [PAT_W-1:0]        row_bits;
   logic [3:0]              row_pop;

   // Board row for the current scan step, wrapped past the bottom edge.
   always_comb begin
      row_y = wrap_add(cy_q, {5'b00000, row_q}, MAX_Y8);
   end

   window_row_read u_row (
      .state    (state),
      .row_y    (row_y),
      .col_base (cx_q),
      .bits     (row_bits),
      .pop      (row_pop)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      accept    = 1'b0;
      reject    = 1'b0;
      abort     = 1'b0;
      scan_step = 1'b0;
      busy      = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (capture) begin
               if (!freeze || (cursor_x >= MAX_X8) || (cursor_y >= MAX_Y8)) begin
                  reject = 1'b1;
               end else begin
                  accept = 1'b1;
                  fsm_d  = SCAN;
               end
            end
         end
         SCAN: begin
            busy = 1'b1;
            // Losing freeze means the board may advance a generation under
            // us, so the partial window is thrown away.
            if (!freeze) begin
               abort = 1'b1;
               fsm_d = IDLE;
            end else begin
               scan_step = 1'b1;
               if (row_q == 3'(PAT_H - 1)) begin
                  fsm_d = DONE;
               end
            end
         end
         DONE: begin
            fsm_d = IDLE;
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cx_q        <= '0;
         cy_q        <= '0;
         row_q       <= '0;
         shadow_q    <= '0;
         acc_q       <= '0;
         pattern_mat <= '0;
         pop_count   <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= (fsm_q == DONE);
         err  <= reject | abort;

         if (accept) begin
            cx_q     <= cursor_x;
            cy_q     <= cursor_y;
            row_q    <= '0;
            shadow_q <= '0;
            acc_q    <= '0;
         end

         if (scan_step) begin
            shadow_q[{row_q, 3'b000} +: PAT_W] <= row_bits;
            acc_q <= acc_q + {3'b000, row_pop};
            row_q <= row_q + 3'd1;
         end

         if (fsm_q == DONE) begin
            pattern_mat <= shadow_q;
            pop_count   <= acc_q;
         end
      end
   end

endmodule

// File: tb/tb_capture_pattern.sv
// tb/tb_capture_pattern.sv - directed vector bench for capture_pattern

module tb_capture_pattern;
   import capture_pattern_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               freeze;
   logic               capture;
   logic [7:0]         cursor_x;
   logic [7:0]         cursor_y;
   logic [STATE_W-1:0] state;
   logic [63:0]        pattern_mat;
   logic [6:0]         pop_count;
   logic               busy;
   logic               done;
   logic               err;

   always #5 clk = ~clk;

   capture_pattern dut (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .capture     (capture),
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .state       (state),
      .pattern_mat (pattern_mat),
      .pop_count   (pop_count),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   typedef struct {
      logic               frz;
      logic [7:0]         cx;
      logic [7:0]         cy;
      logic [STATE_W-1:0] st;
      logic               exp_err;
      logic [63:0]        exp_pat;
      logic [6:0]         exp_pop;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] last_pat = '0;
   logic [6:0]  last_pop = '0;
   vec_t        vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int lat;
      int busy_cnt;
      int both;
      lat      = -1;
      busy_cnt = 0;
      both     = 0;
      @(negedge clk);
      freeze   = v.frz;
      cursor_x = v.cx;
      cursor_y = v.cy;
      state    = v.st;
      capture  = 1'b1;
      @(posedge clk);
      #1 capture = 1'b0;
      if (v.exp_err) begin
         @(negedge clk);
         check($sformatf("vec%0d err", i), 64'(err), 64'd1);
         check($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
         check($sformatf("vec%0d done", i), 64'(done), 64'd0);
         check($sformatf("vec%0d pat_held", i), pattern_mat, last_pat);
         check($sformatf("vec%0d pop_held", i), 64'(pop_count), 64'(last_pop));
         @(negedge clk);
         check($sformatf("vec%0d err_pulse", i), 64'(err), 64'd0);
      end else begin
         for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done && err) both++;
            if (done) lat = k;
         end
         check($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
         check($sformatf("vec%0d busy_cycles", i), 64'(busy_cnt), 64'd8);
         check($sformatf("vec%0d done_and_err", i), 64'(both), 64'd0);
         check($sformatf("vec%0d pattern", i), pattern_mat, v.exp_pat);
         check($sformatf("vec%0d pop", i), 64'(pop_count), 64'(v.exp_pop));
         @(negedge clk);
         check($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
         last_pat = v.exp_pat;
         last_pop = v.exp_pop;
      end
   endtask

   initial begin
      int done_cnt;

      // Only (10,5); cursor (8,4): c=2, r=1 -> bit 10.
      vecs[0].frz = 1; vecs[0].cx = 8;  vecs[0].cy = 4;  vecs[0].st = '0; vecs[0].st[330] = 1'b1;
      vecs[0].exp_err = 0; vecs[0].exp_pat = 64'h0000_0000_0000_0400; vecs[0].exp_pop = 7'd1;
      // Only (1,2); cursor (60,44): c=5, r=6 wrapped both axes -> bit 53.
      vecs[1].frz = 1; vecs[1].cx = 60; vecs[1].cy = 44; vecs[1].st = '0; vecs[1].st[129] = 1'b1;
      vecs[1].exp_err = 0; vecs[1].exp_pat = 64'h0020_0000_0000_0000; vecs[1].exp_pop = 7'd1;
      // Full board at the far corner.
      vecs[2].frz = 1; vecs[2].cx = 63; vecs[2].cy = 47; vecs[2].st = '1;
      vecs[2].exp_err = 0; vecs[2].exp_pat = 64'hFFFF_FFFF_FFFF_FFFF; vecs[2].exp_pop = 7'd64;
      // Rejections: cursor_x out of range, cursor_y out of range, not frozen.
      vecs[3].frz = 1; vecs[3].cx = 64; vecs[3].cy = 0;  vecs[3].st = '0;
      vecs[3].exp_err = 1; vecs[3].exp_pat = '0; vecs[3].exp_pop = '0;
      vecs[4].frz = 1; vecs[4].cx = 0;  vecs[4].cy = 48; vecs[4].st = '0;
      vecs[4].exp_err = 1; vecs[4].exp_pat = '0; vecs[4].exp_pop = '0;
      vecs[5].frz = 0; vecs[5].cx = 0;  vecs[5].cy = 0;  vecs[5].st = '0;
      vecs[5].exp_err = 1; vecs[5].exp_pat = '0; vecs[5].exp_pop = '0;
      // Cursor (0,0): (0,0)->bit0, (3,2)->bit19, (7,7)->bit63, (8,0) outside.
      vecs[6].frz = 1; vecs[6].cx = 0;  vecs[6].cy = 0;  vecs[6].st = '0;
      vecs[6].st[0] = 1'b1; vecs[6].st[2*64+3] = 1'b1; vecs[6].st[7*64+7] = 1'b1; vecs[6].st[8] = 1'b1;
      vecs[6].exp_err = 0; vecs[6].exp_pat = 64'h8000_0000_0008_0001; vecs[6].exp_pop = 7'd3;
      // Cursor (62,0), row 0 cells 62,63,0,5 -> c=0,1,2,7; (6,0) is c=8, outside; (62,8) row outside.
      vecs[7].frz = 1; vecs[7].cx = 62; vecs[7].cy = 0;  vecs[7].st = '0;
      vecs[7].st[62] = 1'b1; vecs[7].st[63] = 1'b1; vecs[7].st[0] = 1'b1; vecs[7].st[5] = 1'b1;
      vecs[7].st[6] = 1'b1; vecs[7].st[8*64+62] = 1'b1;
      vecs[7].exp_err = 0; vecs[7].exp_pat = 64'h0000_0000_0000_0087; vecs[7].exp_pop = 7'd4;

      rst = 1'b0; freeze = 1'b0; capture = 1'b0;
      cursor_x = '0; cursor_y = '0; state = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("reset pattern", pattern_mat, 64'd0);
      check("reset pop", 64'(pop_count), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset err", 64'(err), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i]);
      end

      // Abort: freeze dropped during the scan, plus an ignored second capture.
      @(negedge clk);
      freeze = 1'b1; cursor_x = 8'd0; cursor_y = 8'd0; state = '1; capture = 1'b1;
      @(posedge clk);
      #1 capture = 1'b0;
      @(posedge clk);
      #1 capture = 1'b1; cursor_x = 8'd99;
      @(posedge clk);
      #1 capture = 1'b0;
      @(posedge clk);
      #1 freeze = 1'b0;
      @(negedge clk);
      check("abort busy_before", 64'(busy), 64'd1);
      check("abort ignored_capture_err", 64'(err), 64'd0);
      @(negedge clk);
      check("abort err", 64'(err), 64'd1);
      check("abort busy", 64'(busy), 64'd0);
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort no_done", 64'(done_cnt), 64'd0);
      check("abort pat_held", pattern_mat, last_pat);
      check("abort pop_held", 64'(pop_count), 64'(last_pop));

      // Reset for one edge in the middle of a scan.
      @(negedge clk);
      freeze = 1'b1; cursor_x = 8'd8; cursor_y = 8'd4; state = vecs[0].st; capture = 1'b1;
      @(posedge clk);
      #1 capture = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst pattern", pattern_mat, 64'd0);
      check("midrst pop", 64'(pop_count), 64'd0);
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      last_pat = '0;
      last_pop = '0;
      run_vec(8, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
